// File: rtl/maria_clk_pkg.sv
// rtl/maria_clk_pkg.sv - shared types, defaults and helpers for the MARIA clock/phase generator
package maria_clk_pkg;

  // CPU speed encodings as used by dma_ctrl/memory_map
  typedef enum logic {
    SPEED_FAST = 1'b0,
    SPEED_SLOW = 1'b1
  } speed_t;

  // Entry 0 = fast (1.79M, reload 1), entry 1 = slow (1.19M, reload 2)
  localparam logic [1:0][2:0] DEFAULT_DIV_TABLE = {3'd2, 3'd1};

  // Clamp a possibly negative value at zero
  function automatic int sat0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

endpackage

// File: rtl/maria_nmi_stretch.sv
// rtl/maria_nmi_stretch.sv - stretches a DLI rising edge into an NMI of NMI_CYCLES pclk1 periods
module maria_nmi_stretch #(
  parameter int NMI_CYCLES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic dli_in,
  input  logic pclk1,
  output logic nmi_b
);

  // Counter must reach NMI_CYCLES+1, where the sequence ends
  localparam int CW = $clog2(NMI_CYCLES + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(NMI_CYCLES + 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(NMI_CYCLES);

  logic          dli_q;
  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic          dli_rise;

  assign dli_rise = dli_in & ~dli_q;

  // Edge detect, then count pclk1 periods; a new edge restarts the sequence
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dli_q    <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      dli_q <= dli_in;
      if (dli_rise) begin
        active_q <= 1'b1;
        cnt_q    <= '0;
      end else if (active_q && pclk1) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q + CW'(1) == CNT_LAST) active_q <= 1'b0;
      end
    end
  end

  // Low from the first to the NMI_CYCLES-th pclk1 after the edge
  assign nmi_b = ~(active_q && (cnt_q != '0) && (cnt_q <= CNT_HIGH));

endmodule

// File: rtl/maria_phase_gen.sv
// rtl/maria_phase_gen.sv - MARIA master/CPU phase generator with NMI stretch, READY and line profiling
module maria_phase_gen
  import maria_clk_pkg::*;
#(
  parameter int                                 NUM_SPEEDS = 2,
  parameter int                                 DIV_W      = 3,
  parameter logic [NUM_SPEEDS-1:0][DIV_W-1:0]   DIV_TABLE  = DEFAULT_DIV_TABLE,
  parameter int                                 NMI_CYCLES = 2,
  parameter int                                 CNT_W      = 13,
  localparam int                                SEL_W      = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [SEL_W-1:0] speed_sel,
  input  logic             halt_req,
  input  logic             halt_unlock,
  input  logic             dma_drive,
  input  logic             dli_in,
  input  logic             line_start,
  input  logic             deassert_rdy,
  output logic             mclk0,
  output logic             mclk1,
  output logic             pclk0,
  output logic             pclk1,
  output logic             pclk_edge,
  output logic             nmi_b,
  output logic             ready,
  output logic [CNT_W-1:0] cpu_ticks,
  output logic [CNT_W-1:0] halted_ticks,
  output logic [CNT_W-1:0] driven_ticks
);

  logic             toggle_q;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SEL_W-1:0] last_sel_q, last_sel_d;
  logic             pclk0_q, pclk0_d;
  logic             pclk1_q, pclk1_d;
  logic             ready_q;
  logic [CNT_W-1:0] cpu_q, halted_q, driven_q;
  logic [SEL_W-1:0] sel_eff;
  logic [DIV_W-1:0] reload;

  // Divider next state; only advances on mclk1 ticks, frozen while a halt is unlocked
  always_comb begin
    sel_eff    = (int'(speed_sel) < NUM_SPEEDS) ? speed_sel : '0;
    reload     = DIV_TABLE[sel_eff];
    div_d      = div_q;
    phase_d    = phase_q;
    last_sel_d = last_sel_q;
    pclk0_d    = 1'b0;
    pclk1_d    = 1'b0;
    if (!toggle_q) begin
      if (halt_req && halt_unlock) begin
        pclk0_d = 1'b1;
      end else begin
        if (div_q == '0) begin
          phase_d = ~phase_q;
          pclk1_d = ~phase_q;
          pclk0_d = phase_q;
          div_d   = reload;
        end else begin
          div_d = div_q - DIV_W'(1);
        end
        // A speed change shortens the current half-period to the new reload minus one
        if (sel_eff != last_sel_q) div_d = DIV_W'(sat0(int'(reload) - 1));
        last_sel_d = sel_eff;
      end
    end
  end

  // Master toggle, divider state and registered CPU strobes
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q   <= 1'b0;
      phase_q    <= 1'b0;
      div_q      <= '0;
      last_sel_q <= '0;
      pclk0_q    <= 1'b0;
      pclk1_q    <= 1'b0;
    end else begin
      toggle_q   <= ~toggle_q;
      phase_q    <= phase_d;
      div_q      <= div_d;
      last_sel_q <= last_sel_d;
      pclk0_q    <= pclk0_d;
      pclk1_q    <= pclk1_d;
    end
  end

  // CPU READY: deassert beats line_start
  always_ff @(posedge clk_sys) begin
    if (reset)             ready_q <= 1'b1;
    else if (deassert_rdy) ready_q <= 1'b0;
    else if (line_start)   ready_q <= 1'b1;
  end

  // Per-line profiling counters, cleared by line_start, wrapping otherwise
  always_ff @(posedge clk_sys) begin
    if (reset || line_start) begin
      cpu_q    <= '0;
      halted_q <= '0;
      driven_q <= '0;
    end else begin
      cpu_q    <= cpu_q + CNT_W'(pclk0_q);
      halted_q <= halted_q + CNT_W'(toggle_q & halt_req);
      driven_q <= driven_q + CNT_W'(toggle_q & dma_drive);
    end
  end

  maria_nmi_stretch #(
    .NMI_CYCLES(NMI_CYCLES)
  ) u_nmi (
    .clk_sys(clk_sys),
    .reset  (reset),
    .dli_in (dli_in),
    .pclk1  (pclk1_q),
    .nmi_b  (nmi_b)
  );

  assign mclk0        = toggle_q;
  assign mclk1        = ~toggle_q;
  assign pclk0        = pclk0_q;
  assign pclk1        = pclk1_q;
  assign pclk_edge    = (div_q == DIV_W'(1)) & phase_q;
  assign ready        = ready_q;
  assign cpu_ticks    = cpu_q;
  assign halted_ticks = halted_q;
  assign driven_ticks = driven_q;

endmodule

// File: tb/tb_maria_phase_gen.sv
// tb/tb_maria_phase_gen.sv - scoreboard bench for maria_phase_gen against a behavioural model
module tb_maria_phase_gen;

  localparam int CMOD = 1 << 13;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset = 1'b1, speed_sel = 1'b0, halt_req = 1'b0, halt_unlock = 1'b0;
  logic dma_drive = 1'b0, dli_in = 1'b0, line_start = 1'b0, deassert_rdy = 1'b0;

  logic a_mclk0, a_mclk1, a_pclk0, a_pclk1, a_edge, a_nmi_b, a_ready;
  logic [12:0] a_cpu, a_halt, a_drv;
  logic b_mclk0, b_mclk1, b_pclk0, b_pclk1, b_edge, b_nmi_b, b_ready;
  logic [12:0] b_cpu, b_halt, b_drv;

  maria_phase_gen u_dut (
    .clk_sys(clk_sys), .reset(reset), .speed_sel(speed_sel), .halt_req(halt_req),
    .halt_unlock(halt_unlock), .dma_drive(dma_drive), .dli_in(dli_in),
    .line_start(line_start), .deassert_rdy(deassert_rdy),
    .mclk0(a_mclk0), .mclk1(a_mclk1), .pclk0(a_pclk0), .pclk1(a_pclk1),
    .pclk_edge(a_edge), .nmi_b(a_nmi_b), .ready(a_ready),
    .cpu_ticks(a_cpu), .halted_ticks(a_halt), .driven_ticks(a_drv)
  );

  maria_phase_gen #(.NMI_CYCLES(3)) u_dut3 (
    .clk_sys(clk_sys), .reset(reset), .speed_sel(speed_sel), .halt_req(halt_req),
    .halt_unlock(halt_unlock), .dma_drive(dma_drive), .dli_in(dli_in),
    .line_start(line_start), .deassert_rdy(deassert_rdy),
    .mclk0(b_mclk0), .mclk1(b_mclk1), .pclk0(b_pclk0), .pclk1(b_pclk1),
    .pclk_edge(b_edge), .nmi_b(b_nmi_b), .ready(b_ready),
    .cpu_ticks(b_cpu), .halted_ticks(b_halt), .driven_ticks(b_drv)
  );

  typedef struct {
    int mclk0, mclk1, pclk0, pclk1, pedge, nmi2, nmi3, ready, cpu, halted, driven;
  } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, cyc = 0;
  bit started = 0, done = 0;
  int win_period = 0, win_id = 0;

  // behavioural model state
  int m_tog, m_phase, m_div, m_last, m_p0, m_p1, m_ready, m_cpu, m_halt, m_drv, m_dli_prev;
  int m_act[2], m_n[2];
  int tbl[2] = '{1, 2};
  int nmi_len[2] = '{2, 3};

  task automatic model_step();
    int sel, d, np0, np1;
    if (reset) begin
      m_tog = 0; m_phase = 0; m_div = 0; m_last = 0; m_p0 = 0; m_p1 = 0;
      m_ready = 1; m_cpu = 0; m_halt = 0; m_drv = 0; m_dli_prev = 0;
      for (int k = 0; k < 2; k++) begin m_act[k] = 0; m_n[k] = 0; end
      return;
    end
    sel = (speed_sel < 2) ? int'(speed_sel) : 0;
    d = tbl[sel];
    if (line_start) begin
      m_cpu = 0; m_halt = 0; m_drv = 0;
    end else begin
      m_cpu  = (m_cpu + m_p0) % CMOD;
      m_halt = (m_halt + ((m_tog == 1 && halt_req) ? 1 : 0)) % CMOD;
      m_drv  = (m_drv + ((m_tog == 1 && dma_drive) ? 1 : 0)) % CMOD;
    end
    if (deassert_rdy) m_ready = 0;
    else if (line_start) m_ready = 1;
    for (int k = 0; k < 2; k++) begin
      if (dli_in && m_dli_prev == 0) begin
        m_act[k] = 1; m_n[k] = 0;
      end else if (m_act[k] == 1 && m_p1 == 1) begin
        m_n[k]++;
        if (m_n[k] == nmi_len[k] + 1) m_act[k] = 0;
      end
    end
    m_dli_prev = dli_in ? 1 : 0;
    np0 = 0; np1 = 0;
    if (m_tog == 0) begin
      if (halt_req && halt_unlock) begin
        np0 = 1;
      end else begin
        if (m_div == 0) begin
          if (m_phase == 0) np1 = 1; else np0 = 1;
          m_phase = 1 - m_phase;
          m_div = d;
        end else begin
          m_div--;
        end
        if (sel != m_last) m_div = (d - 1 < 0) ? 0 : d - 1;
        m_last = sel;
      end
    end
    m_p0 = np0; m_p1 = np1;
    m_tog = 1 - m_tog;
  endtask

  function automatic int nmi_exp(input int k);
    return (m_act[k] == 1 && m_n[k] >= 1 && m_n[k] <= nmi_len[k]) ? 0 : 1;
  endfunction

  // inputs are already set; predict the state after the coming edge, then wait for the next negedge
  task automatic step();
    exp_t e;
    model_step();
    e.mclk0 = m_tog; e.mclk1 = 1 - m_tog; e.pclk0 = m_p0; e.pclk1 = m_p1;
    e.pedge = (m_div == 1 && m_phase == 1) ? 1 : 0;
    e.nmi2 = nmi_exp(0); e.nmi3 = nmi_exp(1);
    e.ready = m_ready; e.cpu = m_cpu; e.halted = m_halt; e.driven = m_drv;
    sb.push_back(e);
    started = 1;
    @(negedge clk_sys);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // stimulus: directed scenarios followed by randomized traffic
  initial begin
    steps(4);
    reset = 0;
    // fast steady state
    line_start = 1; step(); line_start = 0;
    steps(10);
    win_period = 8; win_id++;
    dma_drive = 1; steps(40); dma_drive = 0; steps(40);
    win_period = 0; win_id++;
    // slow steady state, switched right after a pclk1
    for (int i = 0; i < 20 && m_p1 == 0; i++) step();
    speed_sel = 1; steps(30);
    win_period = 12; win_id++;
    steps(70);
    win_period = 0; win_id++;
    // halt with unlock for 20 cycles, after a line restart
    speed_sel = 0; steps(20);
    line_start = 1; step(); line_start = 0;
    halt_req = 1; halt_unlock = 1; steps(20);
    halt_req = 0; halt_unlock = 0; steps(20);
    halt_req = 1; steps(10); halt_req = 0; steps(4);
    // NMI single pulse, then a restart mid-pulse
    dli_in = 1; steps(50); dli_in = 0; steps(4);
    dli_in = 1; steps(12); dli_in = 0; steps(2); dli_in = 1; steps(50); dli_in = 0;
    // ready priority
    deassert_rdy = 1; line_start = 1; step();
    deassert_rdy = 0; step(); step();
    line_start = 1; step(); line_start = 0; steps(3);
    // reset mid-period at div=2, phase=1
    speed_sel = 1;
    for (int i = 0; i < 60; i++) begin
      if (m_div == 2 && m_phase == 1 && m_tog == 0) begin
        reset = 1; step(); reset = 0; break;
      end
      step();
    end
    steps(20);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 49) == 0) speed_sel = ~speed_sel;
      if ($urandom_range(0, 29) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 19) == 0) halt_unlock = ~halt_unlock;
      dma_drive = $urandom_range(0, 1);
      if ($urandom_range(0, 14) == 0) dli_in = ~dli_in;
      line_start = ($urandom_range(0, 39) == 0);
      deassert_rdy = ($urandom_range(0, 39) == 0);
      step();
    end
    reset = 0; line_start = 0; deassert_rdy = 0;
    steps(2);
    done = 1;
  end

  // monitor: compare each presented output set with the queued prediction
  initial begin
    exp_t e;
    int last_p0 = -1, last_win = -1;
    forever begin
      @(posedge clk_sys); #1;
      cyc++;
      if (sb.size() == 0) begin
        if (done) break;
        if (started) chk("scoreboard_underrun", 1, 0);
        continue;
      end
      e = sb.pop_front();
      chk("mclk0", a_mclk0, e.mclk0);    chk("mclk1", a_mclk1, e.mclk1);
      chk("pclk0", a_pclk0, e.pclk0);    chk("pclk1", a_pclk1, e.pclk1);
      chk("pclk_edge", a_edge, e.pedge); chk("nmi_b", a_nmi_b, e.nmi2);
      chk("ready", a_ready, e.ready);    chk("cpu_ticks", a_cpu, e.cpu);
      chk("halted_ticks", a_halt, e.halted); chk("driven_ticks", a_drv, e.driven);
      chk("pclk_exclusive", a_pclk0 & a_pclk1, 0);
      chk("n3_pclk0", b_pclk0, e.pclk0); chk("n3_pclk1", b_pclk1, e.pclk1);
      chk("n3_mclk", {b_mclk0, b_mclk1}, e.mclk0 * 2 + e.mclk1);
      chk("n3_pclk_edge", b_edge, e.pedge); chk("n3_nmi_b", b_nmi_b, e.nmi3);
      chk("n3_ready", b_ready, e.ready);
      chk("n3_counters", {b_cpu, b_halt}, e.cpu * CMOD + e.halted);
      chk("n3_driven", b_drv, e.driven);
      if (a_pclk0 === 1'b1) begin
        if (win_period != 0 && last_win == win_id && last_p0 >= 0)
          chk("pclk0_period", cyc - last_p0, win_period);
        last_p0 = cyc;
        last_win = win_id;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout cycle %0d got running expected finished", cyc);
    $fatal(1);
  end

endmodule
